imm_encoder: RTL and testbench

//  Inverse of the immediate generator: packs a 32-bit signed immediate into the
//  I/S/B/J immediate fields of a partially built instruction word. Used by the

---
 rtl/imm_encoder_pkg.sv | 15 +
 rtl/imm_encoder_if.sv | 29 ++
 rtl/imm_encoder_pack.sv | 46 ++++
 rtl/imm_encoder.sv | 82 ++++++++
 tb/tb_imm_encoder.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_encoder_pkg.sv
// Shared constants for the immediate encoder: immediate-format selectors
// (same coding as the decoder's immSrc) and error-flag bit positions.
package imm_encoder_pkg;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam int ERR_RANGE = 0;
  localparam int ERR_ALIGN = 1;

  localparam int ERR_W = 2;

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bundle for imm_encoder. The master drives requests and
// output-ready; the slave (the encoder) returns the packed word and error state.
interface imm_encoder_if #(
  parameter int ERR_CNT_W = 16
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           imm_src;
  logic signed [31:0]   imm;
  logic [31:0]          base;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instr;
  logic [1:0]           out_err;
  logic                 err_clr;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, imm_src, imm, base, out_ready, err_clr,
    input  in_ready, out_valid, out_instr, out_err, err_cnt
  );

  modport slave (
    input  in_valid, imm_src, imm, base, out_ready, err_clr,
    output in_ready, out_valid, out_instr, out_err, err_cnt
  );

endinterface

// File: rtl/imm_encoder_pack.sv
// Combinational packer: scatters a signed immediate into the I/S/B/J fields of
// base and flags out-of-range or odd (B/J) offsets. Bits of base outside the field pass through.
module imm_pack
  import imm_encoder_pkg::*;
(
  input  logic [1:0]         imm_src_i,
  input  logic signed [31:0] imm_i,
  input  logic [31:0]        base_i,
  output logic [31:0]        instr_o,
  output logic [ERR_W-1:0]   err_o
);

  always_comb begin
    instr_o = base_i;
    err_o   = '0;
    // Range holds when every bit above the field's sign bit copies it.
    case (imm_src_i)
      IMM_I: begin
        instr_o[31:20]  = imm_i[11:0];
        err_o[ERR_RANGE] = !((&imm_i[31:11]) || (~|imm_i[31:11]));
      end
      IMM_S: begin
        instr_o[31:25]  = imm_i[11:5];
        instr_o[11:7]   = imm_i[4:0];
        err_o[ERR_RANGE] = !((&imm_i[31:11]) || (~|imm_i[31:11]));
      end
      IMM_B: begin
        instr_o[31]     = imm_i[12];
        instr_o[7]      = imm_i[11];
        instr_o[30:25]  = imm_i[10:5];
        instr_o[11:8]   = imm_i[4:1];
        err_o[ERR_RANGE] = !((&imm_i[31:12]) || (~|imm_i[31:12]));
        err_o[ERR_ALIGN] = imm_i[0];
      end
      default: begin
        instr_o[31]     = imm_i[20];
        instr_o[30:21]  = imm_i[10:1];
        instr_o[20]     = imm_i[11];
        instr_o[19:12]  = imm_i[19:12];
        err_o[ERR_RANGE] = !((&imm_i[31:20]) || (~|imm_i[31:20]));
        err_o[ERR_ALIGN] = imm_i[0];
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder: stage 1 captures the packed word and
// flags, stage 2 is the output register; a saturating counter tallies errored outputs.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  imm_encoder_if.slave  bus
);

  logic [31:0]          pack_instr;
  logic [ERR_W-1:0]     pack_err;

  logic                 vld_p1_q, vld_p1_d;
  logic [31:0]          instr_p1_q;
  logic [ERR_W-1:0]     err_p1_q;
  logic                 vld_p2_q, vld_p2_d;
  logic [31:0]          instr_p2_q;
  logic [ERR_W-1:0]     err_p2_q;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  logic p2_load, p1_adv, in_ready, accept, xfer;

  imm_pack u_pack (
    .imm_src_i (bus.imm_src),
    .imm_i     (bus.imm),
    .base_i    (bus.base),
    .instr_o   (pack_instr),
    .err_o     (pack_err)
  );

  always_comb begin
    p2_load  = !vld_p2_q || bus.out_ready;
    p1_adv   = vld_p1_q && p2_load;
    in_ready = !vld_p1_q || p1_adv;
    accept   = bus.in_valid && in_ready;
    xfer     = vld_p2_q && bus.out_ready;
    vld_p1_d = accept || (vld_p1_q && !p2_load);
    vld_p2_d = p2_load ? vld_p1_q : vld_p2_q;
    cnt_d    = cnt_q;
    if (bus.err_clr)
      cnt_d = '0;
    else if (xfer && (|err_p2_q) && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  // Stage 1: packed word captured on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      instr_p1_q <= pack_instr;
      err_p1_q   <= pack_err;
    end
  end

  // Stage 2: output register, held while the consumer stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      instr_p2_q <= '0;
      err_p2_q   <= '0;
      cnt_q      <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      cnt_q    <= cnt_d;
      if (p1_adv) begin
        instr_p2_q <= instr_p1_q;
        err_p2_q   <= err_p1_q;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p2_q;
  assign bus.out_instr = instr_p2_q;
  assign bus.out_err   = err_p2_q;
  assign bus.err_cnt   = cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and randomized checks of imm_encoder against a decode-based reference
// model; a narrow-counter instance exercises counter saturation.
module tb_imm_encoder;
  import imm_encoder_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imm_encoder_if #(.ERR_CNT_W(16)) bus ();
  imm_encoder_if #(.ERR_CNT_W(4))  sat ();

  imm_encoder #(.ERR_CNT_W(16)) dut   (.clk(clk), .reset(reset), .bus(bus));
  imm_encoder #(.ERR_CNT_W(4))  u_sat (.clk(clk), .reset(reset), .bus(sat));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] base;
    logic [1:0]  err;
  } req_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Immediate generator (the decoder this encoder must invert)
  function automatic logic [31:0] decode(input logic [1:0] src, input logic [31:0] i);
    case (src)
      2'd0:    decode = {{20{i[31]}}, i[31:20]};
      2'd1:    decode = {{20{i[31]}}, i[31:25], i[11:7]};
      2'd2:    decode = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: decode = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  function automatic int fld_w(input logic [1:0] src);
    case (src)
      2'd0, 2'd1: fld_w = 12;
      2'd2:       fld_w = 13;
      default:    fld_w = 21;
    endcase
  endfunction

  function automatic logic [31:0] fld_mask(input logic [1:0] src);
    case (src)
      2'd0:    fld_mask = 32'hFFF0_0000;
      2'd1:    fld_mask = 32'hFE00_0F80;
      2'd2:    fld_mask = 32'hFE00_0F80;
      default: fld_mask = 32'hFFFF_F000;
    endcase
  endfunction

  function automatic logic [1:0] exp_err(input logic [1:0] src, input logic [31:0] imm);
    int n, v, lo, hi;
    logic r, a;
    n  = fld_w(src);
    v  = int'(imm);
    lo = -(1 <<< (n - 1));
    hi = (1 <<< (n - 1)) - 1;
    r  = (v < lo) || (v > hi);
    a  = (src >= 2'd2) && (v % 2 != 0);
    return {a, r};
  endfunction

  // Value the decoder recovers from a packed word: imm truncated to the field width
  function automatic logic [31:0] exp_trunc(input logic [1:0] src, input logic [31:0] imm);
    int t, sh;
    t = int'(imm);
    if (src >= 2'd2) t = t & ~1;
    sh = 32 - fld_w(src);
    t = t <<< sh;
    t = t >>> sh;
    return t;
  endfunction

  task automatic new_req(output req_t r);
    int mode;
    r.src  = 2'($urandom_range(0, 3));
    r.base = $urandom;
    mode   = $urandom_range(0, 3);
    case (mode)
      0:       r.imm = $urandom;
      1:       r.imm = int'($urandom_range(0, 4095)) - 2048;
      2:       r.imm = int'($urandom_range(0, 16383)) - 8192;
      default: r.imm = int'($urandom_range(0, (1 << 22) - 1)) - (1 << 21);
    endcase
    if ($urandom_range(0, 1) == 1) r.imm[0] = 1'b0;
    r.err = exp_err(r.src, r.imm);
  endtask

  task automatic send_check(input string tag, input logic [1:0] src, input logic [31:0] imm,
                            input logic [31:0] base, input logic [31:0] exp_i, input logic [1:0] exp_e);
    bus.in_valid  = 1'b1;
    bus.imm_src   = src;
    bus.imm       = imm;
    bus.base      = base;
    bus.out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_instr"}, bus.out_instr, exp_i);
    chk({tag, "_err"}, 32'(bus.out_err), 32'(exp_e));
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    req_t q[$];
    req_t cur, ex;
    logic [15:0] cnt_m;
    logic held;
    logic [31:0] held_instr;
    logic [1:0]  held_err;
    logic [31:0] bp_exp;
    int sent, got, cyc;

    bus.in_valid = 1'b0; bus.imm_src = 2'd0; bus.imm = '0; bus.base = '0;
    bus.out_ready = 1'b0; bus.err_clr = 1'b0;
    sat.in_valid = 1'b1; sat.imm_src = IMM_B; sat.imm = 32'sd1; sat.base = '0;
    sat.out_ready = 1'b1; sat.err_clr = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed packing
    send_check("i_pack", IMM_I, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 2'b00);
    send_check("s_pack", IMM_S, 32'h0000_07FC, 32'h0000_2023, 32'h7E00_2E23, 2'b00);
    chk("b_cnt_before", 32'(bus.err_cnt), 32'd0);
    send_check("b_err", IMM_B, 32'h0000_1001, 32'h0000_0063, 32'h8000_0063, 2'b11);
    chk("b_cnt_after", 32'(bus.err_cnt), 32'd1);
    send_check("b_neg", IMM_B, 32'hFFFF_F000, 32'h0000_0063, 32'h8000_0063, 2'b00);
    send_check("j_pack", IMM_J, 32'h000F_FFFE, 32'h0000_006F, 32'h7FFF_F06F, 2'b00);
    chk("j_cnt_hold", 32'(bus.err_cnt), 32'd1);

    // err_clr wins over a same-cycle errored transfer
    bus.in_valid = 1'b1; bus.imm_src = IMM_J; bus.imm = 32'h0010_0001; bus.base = 32'h0000_006F;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("clr_err_flags", 32'(bus.out_err), 32'd3);
    bus.err_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.err_clr = 1'b0;
    chk("clr_cnt", 32'(bus.err_cnt), 32'd0);

    // Backpressure: four back-to-back requests, consumer stalled three cycles
    sent = 0; got = 0; held = 1'b0; held_instr = '0; held_err = '0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      bus.out_ready = (c >= 3);
      bus.in_valid  = (sent < 4);
      bus.imm_src   = IMM_I;
      bus.imm       = sent + 1;
      bus.base      = 32'h0000_0013;
      #1;
      if (c == 2) chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      if (held) begin
        chk("bp_hold_vld", 32'(bus.out_valid), 32'd1);
        chk("bp_hold_instr", bus.out_instr, held_instr);
      end
      if (bus.out_valid && bus.out_ready) begin
        bp_exp = ((got + 1) << 20) | 32'h13;
        chk("bp_order", bus.out_instr, bp_exp);
        got++;
      end
      held = bus.out_valid && !bus.out_ready;
      held_instr = bus.out_instr;
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk); @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("bp_delivered", 32'(got), 32'd4);
    #1 chk("bp_no_dup", 32'(bus.out_valid), 32'd0);

    // Reset with both stages full
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.imm_src = IMM_S; bus.imm = 32'sd5;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mid_full_vld", 32'(bus.out_valid), 32'd1);
    chk("mid_full_rdy", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_instr", bus.out_instr, 32'd0);
    @(negedge clk); reset = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("mid_s1_flushed", 32'(bus.out_valid), 32'd0);
    chk("mid_in_ready", 32'(bus.in_ready), 32'd1);

    // Randomized run against the reference model
    cnt_m = '0; sent = 0; got = 0; cyc = 0; held = 1'b0;
    new_req(cur);
    while (got < 10000 && cyc < 60000) begin
      chk("rnd_cnt", 32'(bus.err_cnt), 32'(cnt_m));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.err_clr   = ($urandom_range(0, 63) == 0);
      bus.in_valid  = (sent < 10000) && ($urandom_range(0, 4) != 0);
      bus.imm_src   = cur.src;
      bus.imm       = cur.imm;
      bus.base      = cur.base;
      #1;
      if (held) begin
        chk("rnd_hold_vld", 32'(bus.out_valid), 32'd1);
        chk("rnd_hold_instr", bus.out_instr, held_instr);
        chk("rnd_hold_err", 32'(bus.out_err), 32'(held_err));
      end
      if (bus.err_clr) cnt_m = '0;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_extra_out", 32'd1, 32'(q.size()));
        end else begin
          ex = q.pop_front();
          chk("rnd_err", 32'(bus.out_err), 32'(ex.err));
          chk("rnd_decode", decode(ex.src, bus.out_instr), exp_trunc(ex.src, ex.imm));
          chk("rnd_passthru", bus.out_instr & ~fld_mask(ex.src), ex.base & ~fld_mask(ex.src));
          if (!bus.err_clr && ex.err != 2'b00 && cnt_m != 16'hFFFF) cnt_m = cnt_m + 1'b1;
        end
        got++;
      end
      held = bus.out_valid && !bus.out_ready;
      held_instr = bus.out_instr;
      held_err = bus.out_err;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(cur);
        sent++;
        new_req(cur);
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0; bus.err_clr = 1'b0;
    chk("rnd_delivered", 32'(got), 32'd10000);
    chk("rnd_queue_empty", 32'(q.size()), 32'd0);
    chk("rnd_cnt_final", 32'(bus.err_cnt), 32'(cnt_m));

    // Narrow counter has seen thousands of errored transfers: must sit at all-ones
    chk("sat_full", 32'(sat.err_cnt), 32'h0000_000F);
    repeat (5) @(negedge clk);
    chk("sat_hold", 32'(sat.err_cnt), 32'h0000_000F);
    chk("sat_err_flag", 32'(sat.out_err), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
